id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Decode/operand-fetch stage of the 5-stage 16-bit pipeline (IF -> ID -> EX -> MEM -> WB).
- Consumes the instruction register `id_ir` produced by the fetch stage. Owns the 8x16 general register file.
- Selects operands with EX/MEM/WB forwarding and registers `ex_ir`, `reg_A`, `reg_B` and `smdr` into the EX stage.
- Flushes on a taken branch reported by MEM.

Parameters:
DW, 16, datapath width (fixed by ISA; not intended to change)
RN, 8, number of general registers (3-bit register fields)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low
state  in  1  CPU run state; pipeline advances only when state == `exec
id_ir  in  16  instruction from fetch stage (16'h0000 = NOP bubble)
jump  in  1  taken branch resolved in MEM; flush this stage
ex_ir_fb  in  16  instruction currently in EX (for forwarding)
alu_out  in  16  EX-stage ALU result
mem_ir  in  16  instruction in MEM
reg_C  in  16  MEM-stage result register
wb_ir  in  16  instruction in WB
reg_C1  in  16  WB write-back data
dbg_sel  in  3  debug register select
ex_ir  out  16  instruction passed to EX
reg_A  out  16  operand A to EX
reg_B  out  16  operand B to EX
smdr  out  16  store data for STORE
dbg_data  out  16  gr[dbg_sel], combinational

Behaviour:
- Fields:
  - op = ir[15:11]
  - r1 = ir[10:8]
  - r2 = ir[6:4]
  - r3 = ir[2:0]
  - imm8 = ir[7:0]
  - imm4 = ir[3:0]
- Reset (async, active-low): `ex_ir`, `reg_A`, `reg_B`, `smdr` = 0; all gr[0..7] = 0.
- Hold: when state != `exec`, all outputs and registers hold. No register-file write occurs.
- Writers: ADD, ADDC, SUB, SUBC, AND, OR, XOR, SHL, SHR, CAL, CAR, ADDI, SUBI, MOVI, LOAD write gr[r1]. CMP, STORE, branches, JUMP, NOP and HALT write nothing.
- Register-file write: at a clock edge in `exec`, if wb_ir is a writer, gr[wb_ir.r1] <= reg_C1.
- Operand source value for register index n, in priority order:
  1. EX match: ex_ir_fb is a writer other than LOAD and ex_ir_fb.r1 == n -> alu_out.
  2. MEM match: mem_ir writer and mem_ir.r1 == n -> reg_C.
  3. WB match: wb_ir writer and wb_ir.r1 == n -> reg_C1.
  4. Otherwise gr[n].
- An EX-stage LOAD is never forwarded. Fetch guarantees a bubble in that case.
- Operand selection by op of id_ir:
  - R-type ALU (ADD, ADDC, SUB, SUBC, CMP, AND, OR, XOR): A = src(r2), B = src(r3).
  - Shifts (SHL, SHR, CAL, CAR): A = src(r2), B = {12'b0, imm4}.
  - ADDI/SUBI: A = src(r1), B = {8'b0, imm8}.
  - MOVI: A = 0, B = {8'b0, imm8}.
  - LOAD/STORE: A = src(r2), B = {12'b0, imm4}. smdr = src(r1) for STORE, else 0.
  - Conditional branches (BZ, BNZ, BN, BNN, BC, BNC): A = src(r1), B = {8'b0, imm8}.
  - NOP, HALT, JUMP, undefined: A = 0, B = 0.
- Latency: one cycle. `exec` edge registers `ex_ir` <= id_ir and A/B/smdr per the table.
- Flush: jump == 1 at an `exec` edge -> `ex_ir`, `reg_A`, `reg_B`, `smdr` <= 0. Flush has priority over normal load. The register-file write in the same cycle still occurs.
- Simultaneous write and read of the same register: the WB forward supplies the new value, so there is no read-before-write hazard.
- gr index 0 is an ordinary register; it is not hardwired to zero.
- `dbg_data` reflects the register-file contents only, with no forwarding.
- Reset mid-run: all state clears immediately. The first `exec` edge after release behaves as from power-on.

Decomposition:
- Shared: opcodes (`ADD`…`JUMP`, `LOAD`, `STORE`, branches, `NOP`, `HALT`) and the `exec` state value stay in define.v.
- New shared define: a `writes_reg` classification macro/function in define.v, reused by fetch hazard logic.
- Sub-module id_regfile:
  - 8x16 registers.
  - Async clear, one write port gated by state.
  - Two read ports for operands, plus one read port for `dbg_sel`.

Test Plan:
- Reset, then read: after reset, dbg_sel 0..7 -> dbg_data = 16'h0000. Then id_ir = NOP, exec -> ex_ir = 0, reg_A = reg_B = 0.
- Plain decode: WB writes gr2 = 16'h1234, gr3 = 16'h0011. Later id_ir = ADD r1, r2, r3 -> reg_A = 16'h1234, reg_B = 16'h0011, ex_ir = id_ir after one edge.
- Forward priority: gr2 = 1. wb_ir writes r2 = 16'h0003, mem_ir writes r2 = 16'h0002, ex_ir_fb ADDI r2 with alu_out = 16'h0004. SUB with r2 as A -> reg_A = 16'h0004. Remove the EX match -> 16'h0002.
- Immediates and STORE: MOVI imm 8'hA5 -> reg_A = 0, reg_B = 16'h00A5. STORE r5, [r1 + 4'h7] with gr5 = 16'hBEEF, gr1 = 16'h0010 -> reg_A = 16'h0010, reg_B = 16'h0007, smdr = 16'hBEEF.
- Flush and hold:
  - jump = 1 with id_ir = ADD -> outputs 0 next edge, while a WB write in the same cycle still lands in gr.
  - state != exec for 3 cycles -> outputs unchanged.
- CMP and EX-LOAD non-forward: ex_ir_fb = CMP r2,… or LOAD r2 with alu_out = 16'hFFFF -> reg_A takes the MEM/WB/gr value, not 16'hFFFF.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared ISA definitions for the decode stage: widths, opcodes, run state,
// register-writer classification and the ID->EX payload.
package id_stage_pkg;

   localparam int unsigned DW  = 16;
   localparam int unsigned RN  = 8;
   localparam int unsigned OPW = 5;
   localparam int unsigned RW  = 3;

   localparam logic EXEC = 1'b1;

   localparam logic [OPW-1:0] OP_NOP   = 5'd0;
   localparam logic [OPW-1:0] OP_HALT  = 5'd1;
   localparam logic [OPW-1:0] OP_LOAD  = 5'd2;
   localparam logic [OPW-1:0] OP_STORE = 5'd3;
   localparam logic [OPW-1:0] OP_MOVI  = 5'd4;
   localparam logic [OPW-1:0] OP_ADD   = 5'd8;
   localparam logic [OPW-1:0] OP_ADDI  = 5'd9;
   localparam logic [OPW-1:0] OP_ADDC  = 5'd10;
   localparam logic [OPW-1:0] OP_SUB   = 5'd11;
   localparam logic [OPW-1:0] OP_SUBI  = 5'd12;
   localparam logic [OPW-1:0] OP_SUBC  = 5'd13;
   localparam logic [OPW-1:0] OP_CMP   = 5'd14;
   localparam logic [OPW-1:0] OP_AND   = 5'd15;
   localparam logic [OPW-1:0] OP_OR    = 5'd16;
   localparam logic [OPW-1:0] OP_XOR   = 5'd17;
   localparam logic [OPW-1:0] OP_SHL   = 5'd18;
   localparam logic [OPW-1:0] OP_SHR   = 5'd19;
   localparam logic [OPW-1:0] OP_CAL   = 5'd20;
   localparam logic [OPW-1:0] OP_CAR   = 5'd21;
   localparam logic [OPW-1:0] OP_JUMP  = 5'd24;
   localparam logic [OPW-1:0] OP_BZ    = 5'd25;
   localparam logic [OPW-1:0] OP_BNZ   = 5'd26;
   localparam logic [OPW-1:0] OP_BN    = 5'd27;
   localparam logic [OPW-1:0] OP_BNN   = 5'd28;
   localparam logic [OPW-1:0] OP_BC    = 5'd29;
   localparam logic [OPW-1:0] OP_BNC   = 5'd30;

   // Payload registered from ID into EX.
   typedef struct packed {
      logic [DW-1:0] ir;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] smdr;
   } id_ex_t;

   // True for instructions that write gr[r1]; also used by fetch hazard logic.
   function automatic logic writes_reg(input logic [OPW-1:0] op);
      case (op)
         OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_AND, OP_OR, OP_XOR,
         OP_SHL, OP_SHR, OP_CAL, OP_CAR, OP_ADDI, OP_SUBI, OP_MOVI,
         OP_LOAD:  writes_reg = 1'b1;
         default:  writes_reg = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/id_regfile.sv
// 8x16 general register file.
// Ports: clock/reset (async active-low clear); state gates the single write
// port (wr_en/wr_addr/wr_data); two combinational operand read ports
// (rd_addr_a/b -> rd_data_a_c/b_c) and a debug read port (dbg_sel -> dbg_data).
module id_regfile
   import id_stage_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic          state,
   input  logic          wr_en,
   input  logic [RW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [RW-1:0] rd_addr_a,
   input  logic [RW-1:0] rd_addr_b,
   output logic [DW-1:0] rd_data_a_c,
   output logic [DW-1:0] rd_data_b_c,
   input  logic [RW-1:0] dbg_sel,
   output logic [DW-1:0] dbg_data
);

   logic [DW-1:0] gr [RN];

   // Write port: only while the CPU is executing.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(RN); i++) gr[i] <= '0;
      end else if (state == EXEC && wr_en) begin
         gr[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a_c = gr[rd_addr_a];
   assign rd_data_b_c = gr[rd_addr_b];
   assign dbg_data    = gr[dbg_sel];

endmodule

// File: rtl/id_stage.sv
// Decode / operand-fetch stage: decodes id_ir, reads the register file with
// EX/MEM/WB forwarding and registers ex_ir, reg_A, reg_B, smdr into EX.
// Ports: clock, reset (async active-low), state (advance on EXEC), id_ir,
// jump (flush), ex_ir_fb/alu_out, mem_ir/reg_C, wb_ir/reg_C1 (forward sources,
// WB also writes the register file), dbg_sel/dbg_data (raw register view).
module id_stage
   import id_stage_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic          state,
   input  logic [DW-1:0] id_ir,
   input  logic          jump,
   input  logic [DW-1:0] ex_ir_fb,
   input  logic [DW-1:0] alu_out,
   input  logic [DW-1:0] mem_ir,
   input  logic [DW-1:0] reg_C,
   input  logic [DW-1:0] wb_ir,
   input  logic [DW-1:0] reg_C1,
   input  logic [RW-1:0] dbg_sel,
   output logic [DW-1:0] ex_ir,
   output logic [DW-1:0] reg_A,
   output logic [DW-1:0] reg_B,
   output logic [DW-1:0] smdr,
   output logic [DW-1:0] dbg_data
);

   logic [OPW-1:0] op;
   logic [RW-1:0]  r1, r2, r3;
   logic [RW-1:0]  addr_a, addr_b;
   logic [DW-1:0]  gr_a_c, gr_b_c, src_a_c, src_b_c;
   logic           wb_wr;
   id_ex_t         nxt, q;
   logic           unused_ir_bits;

   assign op = id_ir[15:11];
   assign r1 = id_ir[10:8];
   assign r2 = id_ir[6:4];
   assign r3 = id_ir[2:0];

   assign wb_wr = writes_reg(wb_ir[15:11]);

   // Only the opcode and r1 of downstream instructions matter here.
   assign unused_ir_bits = ^{ex_ir_fb[7:0], mem_ir[7:0], wb_ir[7:0]};

   // Port A reads r1 for ADDI/SUBI/branches, else r2; port B reads r3 for
   // R-type ALU ops, else r1 (STORE data).
   always_comb begin
      addr_a = r2;
      addr_b = r1;
      case (op)
         OP_ADDI, OP_SUBI, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC:
            addr_a = r1;
         OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR:
            addr_b = r3;
         default: ;
      endcase
   end

   id_regfile u_regfile (
      .clock       (clock),
      .reset       (reset),
      .state       (state),
      .wr_en       (wb_wr),
      .wr_addr     (wb_ir[10:8]),
      .wr_data     (reg_C1),
      .rd_addr_a   (addr_a),
      .rd_addr_b   (addr_b),
      .rd_data_a_c (gr_a_c),
      .rd_data_b_c (gr_b_c),
      .dbg_sel     (dbg_sel),
      .dbg_data    (dbg_data)
   );

   // Youngest writer wins; an EX-stage LOAD has no data yet and is skipped.
   function automatic logic [DW-1:0] fwd(
      input logic [RW-1:0] n,    input logic [DW-1:0] gv,
      input logic [DW-1:0] exi,  input logic [DW-1:0] exd,
      input logic [DW-1:0] memi, input logic [DW-1:0] memd,
      input logic [DW-1:0] wbi,  input logic [DW-1:0] wbd);
      if (writes_reg(exi[15:11]) && exi[15:11] != OP_LOAD && exi[10:8] == n)
         fwd = exd;
      else if (writes_reg(memi[15:11]) && memi[10:8] == n)
         fwd = memd;
      else if (writes_reg(wbi[15:11]) && wbi[10:8] == n)
         fwd = wbd;
      else
         fwd = gv;
   endfunction

   assign src_a_c = fwd(addr_a, gr_a_c, ex_ir_fb, alu_out, mem_ir, reg_C, wb_ir, reg_C1);
   assign src_b_c = fwd(addr_b, gr_b_c, ex_ir_fb, alu_out, mem_ir, reg_C, wb_ir, reg_C1);

   // Operand selection by opcode class.
   always_comb begin
      nxt    = '0;
      nxt.ir = id_ir;
      case (op)
         OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR: begin
            nxt.a = src_a_c;
            nxt.b = src_b_c;
         end
         OP_SHL, OP_SHR, OP_CAL, OP_CAR, OP_LOAD: begin
            nxt.a = src_a_c;
            nxt.b = DW'({12'b0, id_ir[3:0]});
         end
         OP_STORE: begin
            nxt.a    = src_a_c;
            nxt.b    = DW'({12'b0, id_ir[3:0]});
            nxt.smdr = src_b_c;
         end
         OP_ADDI, OP_SUBI, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
            nxt.a = src_a_c;
            nxt.b = DW'({8'b0, id_ir[7:0]});
         end
         OP_MOVI:
            nxt.b = DW'({8'b0, id_ir[7:0]});
         default: ;
      endcase
   end

   // ID/EX pipeline register; flush beats a normal load.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         q <= '0;
      else if (state == EXEC)
         q <= jump ? '0 : nxt;
   end

   assign ex_ir = q.ir;
   assign reg_A = q.a;
   assign reg_B = q.b;
   assign smdr  = q.smdr;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized cycles checked
// against a behavioural model of the register file and operand rules.
module tb_id_stage;
   import id_stage_pkg::*;

   logic        clock = 1'b0;
   logic        reset, state, jump;
   logic [15:0] id_ir, ex_ir_fb, alu_out, mem_ir, reg_C, wb_ir, reg_C1;
   logic [2:0]  dbg_sel;
   logic [15:0] ex_ir, reg_A, reg_B, smdr, dbg_data;

   int total = 0;
   int bad   = 0;

   logic [15:0] mgr [8];
   logic [15:0] m_ir, m_a, m_b, m_s;

   always #5 clock = ~clock;

   id_stage dut (
      .clock(clock), .reset(reset), .state(state), .id_ir(id_ir), .jump(jump),
      .ex_ir_fb(ex_ir_fb), .alu_out(alu_out), .mem_ir(mem_ir), .reg_C(reg_C),
      .wb_ir(wb_ir), .reg_C1(reg_C1), .dbg_sel(dbg_sel),
      .ex_ir(ex_ir), .reg_A(reg_A), .reg_B(reg_B), .smdr(smdr), .dbg_data(dbg_data)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] mk(input logic [4:0] op, input int a, input int b, input int c);
      logic [2:0] x, y, z;
      x = 3'(a); y = 3'(b); z = 3'(c);
      return {op, x, 1'b0, y, 1'b0, z};
   endfunction

   function automatic logic [15:0] mki(input logic [4:0] op, input int a, input logic [7:0] imm);
      logic [2:0] x;
      x = 3'(a);
      return {op, x, imm};
   endfunction

   function automatic bit m_writer(input logic [15:0] ir);
      return ir[15:11] inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_AND, OP_OR,
         OP_XOR, OP_SHL, OP_SHR, OP_CAL, OP_CAR, OP_ADDI, OP_SUBI, OP_MOVI, OP_LOAD};
   endfunction

   // Value of register n as seen by ID this cycle.
   function automatic logic [15:0] m_src(input int n);
      if (m_writer(ex_ir_fb) && ex_ir_fb[15:11] != OP_LOAD && int'(ex_ir_fb[10:8]) == n)
         return alu_out;
      if (m_writer(mem_ir) && int'(mem_ir[10:8]) == n) return reg_C;
      if (m_writer(wb_ir) && int'(wb_ir[10:8]) == n) return reg_C1;
      return mgr[n];
   endfunction

   task automatic check_all(input string tag);
      check({tag, "_ir"}, ex_ir, m_ir);
      check({tag, "_a"}, reg_A, m_a);
      check({tag, "_b"}, reg_B, m_b);
      check({tag, "_smdr"}, smdr, m_s);
      check({tag, "_dbg"}, dbg_data, mgr[dbg_sel]);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) mgr[i] = 16'h0;
      m_ir = 0; m_a = 0; m_b = 0; m_s = 0;
   endtask

   // One clock: update the model from pre-edge inputs, then check at negedge.
   task automatic cycle(input string tag);
      logic [4:0] op;
      int r1, r2, r3;
      logic [15:0] a, b, s;
      @(posedge clock);
      op = id_ir[15:11];
      r1 = int'(id_ir[10:8]); r2 = int'(id_ir[6:4]); r3 = int'(id_ir[2:0]);
      a = 0; b = 0; s = 0;
      if (op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR}) begin
         a = m_src(r2); b = m_src(r3);
      end else if (op inside {OP_SHL, OP_SHR, OP_CAL, OP_CAR, OP_LOAD, OP_STORE}) begin
         a = m_src(r2); b = 16'(id_ir[3:0]);
         if (op == OP_STORE) s = m_src(r1);
      end else if (op inside {OP_ADDI, OP_SUBI, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC}) begin
         a = m_src(r1); b = 16'(id_ir[7:0]);
      end else if (op == OP_MOVI) begin
         b = 16'(id_ir[7:0]);
      end
      if (reset && state == EXEC) begin
         if (jump) begin
            m_ir = 0; m_a = 0; m_b = 0; m_s = 0;
         end else begin
            m_ir = id_ir; m_a = a; m_b = b; m_s = s;
         end
         if (m_writer(wb_ir)) mgr[wb_ir[10:8]] = reg_C1;
      end
      @(negedge clock);
      check_all(tag);
   endtask

   task automatic idle();
      state = EXEC; jump = 0; id_ir = 0; ex_ir_fb = 0; alu_out = 0;
      mem_ir = 0; reg_C = 0; wb_ir = 0; reg_C1 = 0; dbg_sel = 0;
   endtask

   task automatic wb_write(input int r, input logic [15:0] v);
      idle();
      wb_ir = mki(OP_MOVI, r, 8'h00); reg_C1 = v;
      cycle("wbw");
      idle();
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      model_clear();
      check_all(tag);
      #1 reset = 1'b1;
   endtask

   logic [15:0] hold_ir;

   initial begin
      idle();
      reset = 1'b0;
      model_clear();
      #2;
      for (int i = 0; i < 8; i++) begin
         dbg_sel = 3'(i);
         #1 check("rst_dbg", dbg_data, 16'h0000);
      end
      check_all("rst");
      @(negedge clock);
      reset = 1'b1;

      idle();
      cycle("nop");
      check("nop_ir", ex_ir, 16'h0000);

      // Plain decode.
      wb_write(2, 16'h1234);
      wb_write(3, 16'h0011);
      id_ir = mk(OP_ADD, 1, 2, 3);
      cycle("add");
      check("add_a", reg_A, 16'h1234);
      check("add_b", reg_B, 16'h0011);
      check("add_ir", ex_ir, mk(OP_ADD, 1, 2, 3));

      // Forwarding priority.
      wb_write(2, 16'h0001);
      id_ir = mk(OP_SUB, 0, 2, 3);
      wb_ir = mki(OP_ADDI, 2, 8'h01); reg_C1 = 16'h0003;
      mem_ir = mki(OP_ADDI, 2, 8'h01); reg_C = 16'h0002;
      ex_ir_fb = mki(OP_ADDI, 2, 8'h01); alu_out = 16'h0004;
      cycle("fwd_ex");
      check("fwd_ex_a", reg_A, 16'h0004);
      ex_ir_fb = 0;
      cycle("fwd_mem");
      check("fwd_mem_a", reg_A, 16'h0002);

      // CMP and EX-stage LOAD are not forwarded.
      ex_ir_fb = mk(OP_CMP, 2, 0, 0); alu_out = 16'hFFFF;
      cycle("cmp");
      check("cmp_a", reg_A, 16'h0002);
      ex_ir_fb = mk(OP_LOAD, 2, 0, 0);
      cycle("ldx");
      check("ldx_a", reg_A, 16'h0002);
      mem_ir = 0; wb_ir = 0;
      cycle("ldx_gr");
      check("ldx_gr_a", reg_A, 16'h0003);

      // Immediates and STORE.
      idle();
      id_ir = mki(OP_MOVI, 4, 8'hA5);
      cycle("movi");
      check("movi_a", reg_A, 16'h0000);
      check("movi_b", reg_B, 16'h00A5);
      wb_write(5, 16'hBEEF);
      wb_write(1, 16'h0010);
      id_ir = mk(OP_STORE, 5, 1, 7);
      cycle("st");
      check("st_a", reg_A, 16'h0010);
      check("st_b", reg_B, 16'h0007);
      check("st_smdr", smdr, 16'hBEEF);

      // Flush with concurrent WB write.
      idle();
      id_ir = mk(OP_ADD, 1, 2, 3); jump = 1;
      wb_ir = mki(OP_MOVI, 6, 8'h00); reg_C1 = 16'h5555; dbg_sel = 3'd6;
      cycle("flush");
      check("flush_ir", ex_ir, 16'h0000);
      check("flush_a", reg_A, 16'h0000);
      check("flush_gr6", dbg_data, 16'h5555);

      // Hold for three cycles.
      idle();
      hold_ir = mki(OP_MOVI, 0, 8'h77);
      id_ir = hold_ir;
      cycle("pre_hold");
      state = ~EXEC; id_ir = mk(OP_ADD, 1, 2, 3); jump = 1;
      wb_ir = mki(OP_MOVI, 7, 8'h00); reg_C1 = 16'h9999; dbg_sel = 3'd7;
      for (int i = 0; i < 3; i++) begin
         cycle("hold");
         check("hold_ir", ex_ir, hold_ir);
         check("hold_b", reg_B, 16'h0077);
         check("hold_gr7", dbg_data, 16'h0000);
      end

      // Mid-run reset.
      idle();
      do_reset("midrst");

      // Randomized cycles.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(299) == 0) do_reset("rrst");
         state    = ($urandom_range(7) != 0) ? EXEC : ~EXEC;
         jump     = ($urandom_range(9) == 0);
         id_ir    = 16'($urandom);
         ex_ir_fb = 16'($urandom);
         alu_out  = 16'($urandom);
         mem_ir   = 16'($urandom);
         reg_C    = 16'($urandom);
         wb_ir    = 16'($urandom);
         reg_C1   = 16'($urandom);
         dbg_sel  = 3'($urandom);
         cycle("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
